// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package somador_pkg;

    localparam int N_PADRAO = 8;

    // 2'b11 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SOMA = 2'b01,
        FIM  = 2'b10
    } estado_t;

endpackage

// File: rtl/somador_completo.sv
// One-bit combinational full adder, the single arithmetic cell reused every cycle by the serial adder.
module somador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_serial_8bits.sv
// Bit-serial N-bit unsigned adder: latches A/B on start, adds one bit per clock LSB first,
// and presents the (N+1)-bit sum with a one-cycle done pulse.
module somador_serial_8bits
    import somador_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N:0]   S
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_ULTIMO = KW'(N - 1);

    estado_t       estado;
    estado_t       proximo;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic [N-1:0]  soma;
    logic          c;
    logic [KW-1:0] k;
    logic          s_bit;
    logic          c_out;

    somador_completo u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (c),
        .s    (s_bit),
        .cout (c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) estado <= IDLE;
        else     estado <= proximo;
    end

    always_comb begin
        proximo = IDLE;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (estado)
            IDLE: begin
                ready   = 1'b1;
                proximo = start ? SOMA : IDLE;
            end
            SOMA: begin
                busy    = 1'b1;
                proximo = (k == K_ULTIMO) ? FIM : SOMA;
            end
            FIM: begin
                done    = 1'b1;
                proximo = IDLE;
            end
            default: proximo = IDLE;
        endcase
    end

    // S is loaded on the last SOMA edge so it is already valid during the FIM cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            soma <= '0;
            c    <= 1'b0;
            k    <= '0;
            S    <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (start) begin
                        ra   <= A;
                        rb   <= B;
                        soma <= '0;
                        c    <= 1'b0;
                        k    <= '0;
                    end
                end
                SOMA: begin
                    ra   <= ra >> 1;
                    rb   <= rb >> 1;
                    c    <= c_out;
                    k    <= k + 1'b1;
                    soma <= {s_bit, soma[N-1:1]};
                    if (k == K_ULTIMO) S <= {c_out, s_bit, soma[N-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial_8bits.sv
// Self-checking bench for somador_serial_8bits: directed table, corner sequences and a random sweep.
module tb_somador_serial_8bits;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N:0]   S;

    int vectors;
    int miscompares;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0]   s;
    } vec_t;

    somador_serial_8bits #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Runs one addition from acceptance to done, optionally poking start mid-SOMA and in FIM.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input bit noise, input string tag);
        int n;
        int cyc;
        int bcnt;
        logic [N:0] exp_s;
        exp_s = {1'b0, a} + {1'b0, b};
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        checkOutput({tag, " ready before start"}, int'(ready), 1);
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            if (noise && cyc == 3) begin
                start = 1'b1;
                A = 8'hAA;
                B = 8'h55;
            end else begin
                start = 1'b0;
                A = N'($urandom);
                B = N'($urandom);
            end
            step();
            cyc++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        checkOutput({tag, " done seen"}, int'(done), 1);
        checkOutput({tag, " latency"}, cyc, N + 1);
        checkOutput({tag, " busy cycles"}, bcnt, N);
        checkOutput({tag, " sum"}, int'(S), int'(exp_s));
        if (noise) start = 1'b1;
        step();
        start = 1'b0;
        checkOutput({tag, " done one cycle"}, int'(done), 0);
        checkOutput({tag, " ready after"}, int'(ready), 1);
        if (noise) begin
            for (int i = 0; i < 3; i++) begin
                step();
                checkOutput({tag, " no extra op"}, int'(busy | done), 0);
            end
            checkOutput({tag, " sum held"}, int'(S), int'(exp_s));
        end
    endtask

    initial begin
        vec_t tbl[6];
        int   n;
        int   cyc;

        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;

        tbl[0] = '{8'h05, 8'h03, 9'h008};
        tbl[1] = '{8'hFF, 8'h01, 9'h100};
        tbl[2] = '{8'hFF, 8'hFF, 9'h1FE};
        tbl[3] = '{8'h00, 8'h00, 9'h000};
        tbl[4] = '{8'h00, 8'hFF, 9'h0FF};
        tbl[5] = '{8'h80, 8'h7F, 9'h0FF};

        step();
        step();
        checkOutput("reset ready", int'(ready), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset S", int'(S), 0);

        // rst and start together: reset must win and no operation may begin.
        start = 1'b1;
        A = 8'h11;
        B = 8'h22;
        step();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst+start ready", int'(ready), 1);
        step();
        checkOutput("rst+start busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].a, tbl[i].b, 1'b0, $sformatf("table%0d", i));
            checkOutput($sformatf("table%0d constant", i), int'(S), int'(tbl[i].s));
        end

        applyStimulus(8'h10, 8'h20, 1'b1, "ignored start");
        checkOutput("ignored start S", int'(S), 9'h030);

        // Reset during the fourth busy cycle discards the partial result.
        A = 8'h7F;
        B = 8'h7F;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checkOutput("pre-reset busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midreset ready", int'(ready), 1);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset done", int'(done), 0);
        checkOutput("midreset S", int'(S), 0);
        applyStimulus(8'h01, 8'h02, 1'b0, "after reset");

        // Start held high continuously: one result every N+2 cycles.
        A = 8'h80;
        B = 8'h80;
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        checkOutput("b2b first done", int'(done), 1);
        checkOutput("b2b first S", int'(S), 9'h100);
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (!done && cyc < 40);
            checkOutput("b2b period", cyc, N + 2);
            checkOutput("b2b S", int'(S), 9'h100);
        end
        start = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        checkOutput("b2b drain ready", int'(ready), 1);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
